// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out
// start / 5-8 data / optional parity / 1, 1.5 or 2 stop bits on 16x baud ticks.
module uart_tx_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       fifo_rempty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_stb,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_sp,
  input  logic       lcr_bc,
  output logic       txd,
  output logic       tx_busy,
  output logic       temt
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [4:0] tick_cnt;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       line_q;
  logic [1:0] wls_q;
  logic       stb_q;
  logic       pen_q;
  logic       par_q;

  logic [4:0] last_cnt;
  logic       bit_end;
  logic [7:0] data_mask;
  logic       par_calc;

  always_comb begin
    last_cnt = 5'd15;
    if (state == STOP && stb_q)
      last_cnt = (wls_q == 2'd0) ? 5'd23 : 5'd31;
    bit_end = baud_tick && (tick_cnt == last_cnt);

    unique case (lcr_wls)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase

    if (lcr_sp)
      par_calc = ~lcr_eps;
    else if (lcr_eps)
      par_calc = ^(fifo_data & data_mask);
    else
      par_calc = ~^(fifo_data & data_mask);
  end

  assign fifo_read = (state == IDLE) && !fifo_rempty && !rst;
  assign tx_busy   = (state != IDLE);
  assign temt      = (state == IDLE) && fifo_rempty;

  // line_q is the frame's own bit value; txd is line_q's next value gated by
  // break, so releasing break restores the live bit after one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      line_q   <= 1'b1;
      txd      <= 1'b1;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      txd <= line_q & ~lcr_bc;
      if (state != IDLE && state != LOAD && baud_tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 5'd1;

      unique case (state)
        IDLE: begin
          if (fifo_read)
            state <= LOAD;
        end
        LOAD: begin
          shreg    <= fifo_data;
          wls_q    <= lcr_wls;
          stb_q    <= lcr_stb;
          pen_q    <= lcr_pen;
          par_q    <= par_calc;
          tick_cnt <= '0;
          bit_idx  <= '0;
          line_q   <= 1'b0;
          txd      <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            line_q <= shreg[0];
            txd    <= shreg[0] & ~lcr_bc;
            state  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == {1'b1, wls_q}) begin
              if (pen_q) begin
                line_q <= par_q;
                txd    <= par_q & ~lcr_bc;
                state  <= PARITY;
              end else begin
                line_q <= 1'b1;
                txd    <= ~lcr_bc;
                state  <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              line_q  <= shreg[1];
              txd     <= shreg[1] & ~lcr_bc;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            line_q <= 1'b1;
            txd    <= ~lcr_bc;
            state  <= STOP;
          end
        end
        STOP: begin
          if (bit_end)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
